// File: rtl/cistercian_digit_scanner.sv
// cistercian_digit_scanner: 14-bit binary to 4-digit BCD (double-dabble) feeding a
// two-phase multiplexed Cistercian glyph decoder with blanking between phases.
module cistercian_digit_scanner #(
   parameter int DIV_WIDTH    = 8,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] value,
   input  logic        load,
   output logic        ready,
   output logic [3:0]  dig1,
   output logic [3:0]  dig2,
   output logic        pair_sel,
   output logic        bi,
   output logic        ovf
);
   typedef enum logic {IDLE, CONVERT} state_t;
   localparam logic [DIV_WIDTH-1:0] BLANK = DIV_WIDTH'(BLANK_CYCLES);
   state_t state, state_n;
   logic [13:0] sh;
   logic [15:0] acc, adj, disp;
   logic [3:0] cnt;
   logic vld, vld_n, ovf_n, start, reject, done;
   logic [DIV_WIDTH-1:0] sc, sc_n;
   assign ready = state == IDLE;
   assign start = ready && load && value <= 14'd9999;
   assign reject = ready && load && value > 14'd9999;
   assign done = state == CONVERT && cnt == 4'd1;
   assign vld_n = vld || done;
   assign ovf_n = done ? 1'b0 : reject ? 1'b1 : ovf;
   assign sc_n = sc + 1'b1;
   assign dig1 = pair_sel ? disp[11:8] : disp[3:0];
   assign dig2 = pair_sel ? disp[15:12] : disp[7:4];
   always_comb begin
      state_n = start ? CONVERT : done ? IDLE : state;
      adj = acc;
      for (int i = 0; i < 4; i++)
         adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   // bi looks at next-cycle valid/ovf/counter so it is exact on the edge it changes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh <= '0;
         acc <= '0;
         cnt <= '0;
         disp <= '0;
         vld <= 1'b0;
         ovf <= 1'b0;
         sc <= '0;
         pair_sel <= 1'b0;
         bi <= 1'b0;
      end else begin
         sc <= sc_n;
         if (sc_n == '0) pair_sel <= ~pair_sel;
         vld <= vld_n;
         ovf <= ovf_n;
         bi <= vld_n && !ovf_n && sc_n >= BLANK;
         if (start) begin
            sh <= value;
            acc <= '0;
            cnt <= 4'd14;
         end else if (state == CONVERT) begin
            {acc, sh} <= 30'({adj, sh, 1'b0});
            cnt <= cnt - 4'd1;
         end
         if (done) disp <= 16'({adj, sh[13]});
      end
   end
endmodule

// File: doc/cistercian_digit_scanner.md
CISTERCIAN_DIGIT_SCANNER -- requirements
Module: cistercian_digit_scanner

Interface
REQ-001 Parameter DIV_WIDTH, default 8: scan counter width; each display phase lasts 2^DIV_WIDTH cycles.
REQ-002 Parameter BLANK_CYCLES, default 4: cycles at the start of each phase with bi low; legal range 0 .. 2^DIV_WIDTH-1.
REQ-003 Port clk  in  1  the only clock; all state changes on its rising edge.
REQ-004 Port rst_n  in  1  reset; asynchronous and active-low.
REQ-005 Port value  in  14  binary number to display, 0..9999 legal.
REQ-006 Port load  in  1  request to convert value; accepted when load & ready at a rising edge.
REQ-007 Port ready  out  1  high when a load can be accepted.
REQ-008 Port dig1  out  4  units digit (phase 0) or hundreds digit (phase 1), BCD; bit0 drives decoder A1, bit3 drives D1.
REQ-009 Port dig2  out  4  tens digit (phase 0) or thousands digit (phase 1), BCD; bit0 drives A2, bit3 drives D2.
REQ-010 Port pair_sel  out  1  current phase: 0 = units/tens glyph pair, 1 = hundreds/thousands glyph pair.
REQ-011 Port bi  out  1  blanking enable to the decoder BI input; high = display lit.
REQ-012 Port ovf  out  1  high when the last accepted value exceeded 9999.

Function
REQ-013 The block SHALL have states IDLE and CONVERT; ready = 1 in IDLE and 0 in CONVERT.
REQ-014 In IDLE, an accepted load with value <= 9999 SHALL capture value, clear a 16-bit BCD accumulator, load an iteration counter with 14 and enter CONVERT.
REQ-015 In CONVERT, each cycle SHALL add 3 to every accumulator nibble >= 5, then shift {accumulator, value shift register} left by one, and decrement the counter (double-dabble).
REQ-016 On the edge that completes iteration 14, the block SHALL write all four digits atomically to the display register, set a displayed-valid flag, clear ovf and return to IDLE.
REQ-017 Latency: load accepted at edge E0; digits and ready=1 visible after edge E14; ready low after E0 through E13.
REQ-018 An accepted load with value > 9999 SHALL set ovf, leave the display register unchanged and remain in IDLE (ready stays 1).
REQ-019 load while in CONVERT SHALL be ignored with no effect on the conversion in progress.
REQ-020 The display register SHALL NOT change during CONVERT; the old digits keep scanning.
REQ-021 A free-running DIV_WIDTH-bit scan counter SHALL increment every cycle and wrap to 0; pair_sel SHALL toggle on the edge at which the counter wraps.
REQ-022 dig1/dig2 SHALL be a combinational select of the display register by pair_sel (registered digits, no glitch beyond the mux).
REQ-023 bi SHALL be registered and equal 1 only when displayed-valid = 1, ovf = 0 and the scan counter >= BLANK_CYCLES.
REQ-024 With BLANK_CYCLES = 0, bi SHALL stay high across phase changes when valid and not ovf.
REQ-025 Scanning SHALL run independently of load/convert state; simultaneous wrap and conversion completion take effect on the same edge.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, ready 1, display register 0, dig1 0, dig2 0, pair_sel 0, scan counter 0, bi 0, ovf 0, displayed-valid 0.
REQ-027 Reset asserted mid-conversion SHALL abort it; no partial digits are ever written.
REQ-028 After reset release, bi SHALL remain 0 until the first successful conversion completes.

Verification
REQ-029 load value=1234 -> ready low 14 cycles; then pair_sel=0: dig1=4, dig2=3; pair_sel=1: dig1=2, dig2=1; bi=1 outside blank window.
REQ-030 load 9999 -> all digits 9; subsequent load 0 -> all digits 0, bi=1, ovf=0.
REQ-031 load 10000 -> ovf=1, bi=0 next cycle, ready stays 1, digits unchanged; then load 5 -> after 14 cycles ovf=0, dig1=5 in phase 0.
REQ-032 load 42, then load 7 at cycle 3 of CONVERT -> result digits 2,4,0,0; 7 never appears.
REQ-033 DIV_WIDTH=3, BLANK_CYCLES=2 -> pair_sel toggles every 8 cycles; bi low for exactly 2 cycles after each toggle.
REQ-034 rst_n pulsed low at CONVERT cycle 7 -> all outputs at reset values without waiting for clk; next load converts correctly.
